pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, stall, flush with bubble insertion, an optional two-entry skid buffer, and a saturating stall-cycle counter. It generalises the fixed IF/ID latch into a single block that every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates. On flush, the payload is split into a preserved field and a bubble field.

---
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with valid/ready
// handshake, stall, flush-with-bubble and a saturating stall-cycle counter.
// Optional build macro PIPE_SKID_EN: adds a second (skid) entry so that
// In_Ready depends on registered state only. Without it, a single register
// is built and In_Ready is combinational from Out_Ready.
// On flush the upper PRESERVE_W bits load from Data_In and the lower field
// takes BUBBLE; reset writes zeros above BUBBLE.
module pipe_stage_reg #(
  parameter int unsigned                    DATA_W     = 64,
  parameter int unsigned                    PRESERVE_W = 32,
  parameter logic [DATA_W-PRESERVE_W-1:0]   BUBBLE     = '0,
  parameter int unsigned                    CNT_W      = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] Data_In,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Data_Out,
  output logic [CNT_W-1:0]  Stall_Count
);

  // Lower (bubble) field mask; a mask rather than a slice keeps
  // PRESERVE_W = 0 legal.
  localparam logic [DATA_W-1:0] LOW_MASK   = {DATA_W{1'b1}} >> PRESERVE_W;
  localparam logic [DATA_W-1:0] BUBBLE_EXT = DATA_W'(BUBBLE);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              drain;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  // Ready depends only on skid occupancy (plus control inputs).
  assign In_Ready = RESET & ~FLUSH & ~STALL & ~skid_valid_q;
`else
  // Ready passes Out_Ready straight through when the register is full.
  assign In_Ready = RESET & ~FLUSH & ~STALL & (~main_valid_q | Out_Ready);
`endif

  assign accept      = In_Valid & In_Ready;
  assign drain       = main_valid_q & Out_Ready;
  assign Out_Valid   = main_valid_q;
  assign Data_Out    = main_q;
  assign Stall_Count = cnt_q;

  // Next-state: flush beats stall beats normal handshake.
  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    cnt_d        = cnt_q;
`ifdef PIPE_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
`endif
    if (FLUSH) begin
      main_valid_d = 1'b0;
      main_d       = (Data_In & ~LOW_MASK) | BUBBLE_EXT;
`ifdef PIPE_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else if (STALL) begin
      if (main_valid_q && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
`ifdef PIPE_SKID_EN
      // Skid is only ever full while main is full, and blocks accept,
      // so a drain with skid full is a pure skid->main move.
      if (drain && skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (drain || !main_valid_q) begin
        main_valid_d = accept;
        if (accept) begin
          main_d = Data_In;
        end
      end else if (accept) begin
        skid_d       = Data_In;
        skid_valid_d = 1'b1;
      end
`else
      if (accept) begin
        main_d       = Data_In;
        main_valid_d = 1'b1;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end
`endif
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      main_valid_q <= 1'b0;
      main_q       <= BUBBLE_EXT;
      cnt_q        <= '0;
`ifdef PIPE_SKID_EN
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
`endif
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      cnt_q        <= cnt_d;
`ifdef PIPE_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: two instances (default parameters, and a
// narrow-counter / different-bubble variant) driven by the same stimulus,
// checked against a queue-based reference model.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam logic [63:0] MASK1 = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] BUB1  = 64'h0;
  localparam logic [63:0] MASK2 = 64'h0000_FFFF_FFFF_FFFF;
  localparam logic [63:0] BUB2  = 64'h13;

  logic        clk;
  logic        rst_n, stall, flush, in_valid, out_ready;
  logic [63:0] din;
  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [63:0] dout, dout2;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: in-flight payloads in order, last visible payload
  // per instance, and the stall counters.
  logic [63:0] q[$];
  logic [63:0] m_dout, m_dout2;
  int unsigned m_cnt, m_cnt4;

  pipe_stage_reg #(
    .DATA_W(64), .PRESERVE_W(32), .BUBBLE(32'h0), .CNT_W(16)
  ) dut (
    .CLOCK(clk), .RESET(rst_n), .STALL(stall), .FLUSH(flush),
    .In_Valid(in_valid), .In_Ready(in_ready), .Data_In(din),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Data_Out(dout),
    .Stall_Count(cnt16)
  );

  pipe_stage_reg #(
    .DATA_W(64), .PRESERVE_W(16), .BUBBLE(48'h13), .CNT_W(4)
  ) dut2 (
    .CLOCK(clk), .RESET(rst_n), .STALL(stall), .FLUSH(flush),
    .In_Valid(in_valid), .In_Ready(in_ready2), .Data_In(din),
    .Out_Valid(out_valid2), .Out_Ready(out_ready), .Data_Out(dout2),
    .Stall_Count(cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = BUB1;
    m_dout2 = BUB2;
    m_cnt   = 0;
    m_cnt4  = 0;
  endtask

  // One clock cycle: drive at negedge, check outputs against the model,
  // advance the model, and return 1 time unit after the rising edge.
  task automatic step(input bit rst, input bit stl, input bit fl, input bit iv,
                      input logic [63:0] d, input bit ordy);
    bit exp_rdy;
    @(negedge clk);
    rst_n = rst; stall = stl; flush = fl; in_valid = iv; din = d; out_ready = ordy;
    #1;
    exp_rdy = rst && !fl && !stl &&
              (SKID ? (q.size() < 2) : (q.size() == 0 || ordy));
    check("in_ready",   64'(in_ready),   64'(exp_rdy));
    check("in_ready2",  64'(in_ready2),  64'(exp_rdy));
    check("out_valid",  64'(out_valid),  64'(q.size() != 0));
    check("out_valid2", 64'(out_valid2), 64'(q.size() != 0));
    check("data_out",   dout,  m_dout);
    check("data_out2",  dout2, m_dout2);
    check("stall_cnt",  64'(cnt16), 64'(m_cnt));
    check("stall_cnt4", 64'(cnt4),  64'(m_cnt4));
    if (!rst) begin
      model_reset();
    end else if (fl) begin
      q.delete();
      m_dout  = (d & ~MASK1) | BUB1;
      m_dout2 = (d & ~MASK2) | BUB2;
    end else if (stl) begin
      if (q.size() != 0) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (iv && exp_rdy) q.push_back(d);
      if (q.size() != 0) begin
        m_dout  = q[0];
        m_dout2 = q[0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] v;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; din = '0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  dout,  64'h0);
    check("rst_data2", dout2, 64'h13);
    check("rst_cnt",   64'(cnt16), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);

    // Streaming at full rate.
    for (int unsigned i = 0; i < 4; i++) begin
      v = 64'h11 + 64'(i);
      step(1, 0, 0, 1, v, 1);
      check("stream_data",  dout, v);
      check("stream_valid", 64'(out_valid), 64'd1);
    end

    // Flush with a live payload on the input.
    step(1, 0, 1, 1, 64'h0000_0040_DEAD_BEEF, 1);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_data",  dout,  64'h0000_0040_0000_0000);
    check("flush_data2", dout2, 64'h0000_0000_0000_0013);

    // Stall five cycles with a valid payload, then flush during stall.
    step(0, 0, 0, 0, '0, 0);
    step(1, 0, 0, 1, 64'h55, 0);
    for (int unsigned i = 0; i < 5; i++) step(1, 1, 0, 1, 64'h66, 1);
    check("stall_cnt5",  64'(cnt16), 64'd5);
    check("stall_hold",  dout, 64'h55);
    check("stall_ready", 64'(in_ready), 64'd0);
    step(1, 1, 1, 1, 64'h1234_5678_0000_0001, 1);
    check("stall_flush_valid", 64'(out_valid), 64'd0);
    check("stall_flush_data",  dout, 64'h1234_5678_0000_0000);
    check("stall_flush_cnt",   64'(cnt16), 64'd5);

    // Back-pressure: main full, Out_Ready low, offer 0xA.
    step(1, 0, 0, 1, 64'h77, 0);
    step(1, 0, 0, 1, 64'hA, 0);
    check("bp_ready", 64'(in_ready), 64'd0);
    check("bp_first", dout, 64'h77);
    step(1, 0, 0, 0, '0, 1);
    check("bp_second_valid", 64'(out_valid), 64'(SKID));
    step(1, 0, 0, 0, '0, 1);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Counter saturation on the 4-bit instance.
    step(1, 0, 0, 1, 64'h99, 0);
    for (int unsigned i = 0; i < 20; i++) step(1, 1, 0, 0, '0, 1);
    check("sat_cnt4", 64'(cnt4), 64'd15);
    check("sat_cnt16", 64'(cnt16), 64'd25);

    // Randomised traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      step($urandom_range(63) != 0, $urandom_range(5) == 0,
           $urandom_range(15) == 0, $urandom_range(2) != 0,
           {$urandom, $urandom}, $urandom_range(2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
